mc_control: RTL and testbench

Multi-cycle control sequencer for the RV32I core: replaces the single-cycle decode-only control unit with an FSM that drives a shared datapath (one ALU, one unified memory port) through fetch, decode, execute, memory and writeback. It sits between the instruction register and the datapath. It consumes the opcode, funct3 and funct7 fields plus the branch-compare result. It emits per-cycle register/PC/IR write strobes, ALU controls and a req/ready memory handshake.

---
 rtl/mc_control.sv | 234 +++++++++++++++++++++++
 tb/tb_mc_control.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT FSM driving a shared ALU and memory port.
// Optional retired-instruction counter output 'instret' is enabled by defining MC_CONTROL_INSTRET_EN.
module mc_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       mdr_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src,
  output logic [3:0] alu_op,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic [2:0] state,
  output logic       illegal
`ifdef MC_CONTROL_INSTRET_EN
  ,
  output logic [31:0] instret
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR
  } cls_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STOR = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  state_e state_q, state_d;
  cls_e   cls_q, cls_d;
  logic   illegal_q, illegal_d;

  function automatic cls_e decode_class(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7);
    cls_e c;
    c = C_NONE;
    case (op)
      OP_R: begin
        if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
          c = C_R;
      end
      OP_I:    c = C_I;
      OP_LOAD: c = C_LOAD;
      OP_STOR: c = C_STORE;
      OP_BR:   c = C_BRANCH;
      OP_JAL:  c = C_JAL;
      OP_JALR: c = C_JALR;
      default: c = C_NONE;
    endcase
    return c;
  endfunction

  // 'alt' is funct7[5] already qualified by the caller for the instruction class.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    // NOTE: every output and next-state signal gets a default first so no path infers a latch.
    state_d      = state_q;
    cls_d        = cls_q;
    illegal_d    = illegal_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    mdr_we       = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'b00;
    alu_src      = 2'b00;
    alu_op       = ALU_ADD;
    reg_write    = 1'b0;
    wb_sel       = 2'b00;

    // Outputs are held quiet in the reset cycle so an abandoned request never fires a strobe.
    if (!rst) begin
      unique case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          cls_d = decode_class(opcode, funct3, funct7);
          if (cls_d == C_NONE) begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          unique case (cls_q)
            C_R: begin
              alu_op  = arith_op(funct3, funct7[5]);
              state_d = S_WB;
            end
            C_I: begin
              alu_src = 2'b01;
              alu_op  = arith_op(funct3, (funct3 == 3'b101) && funct7[5]);
              state_d = S_WB;
            end
            C_LOAD, C_STORE: begin
              alu_src = 2'b01;
              state_d = S_MEM;
            end
            C_BRANCH: begin
              alu_op  = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
              pc_we   = 1'b1;
              pc_src  = br_taken ? 2'b01 : 2'b00;
              state_d = S_FETCH;
            end
            C_JAL: begin
              pc_we     = 1'b1;
              pc_src    = 2'b01;
              reg_write = 1'b1;
              wb_sel    = 2'b10;
              state_d   = S_FETCH;
            end
            C_JALR: begin
              alu_src   = 2'b01;
              pc_we     = 1'b1;
              pc_src    = 2'b10;
              reg_write = 1'b1;
              wb_sel    = 2'b10;
              state_d   = S_FETCH;
            end
            default: begin
              state_d   = S_HALT;
              illegal_d = 1'b1;
            end
          endcase
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (cls_q == C_STORE);
          alu_src      = 2'b01;
          if (mem_ready) begin
            if (cls_q == C_STORE) begin
              pc_we   = 1'b1;
              state_d = S_FETCH;
            end else begin
              mdr_we  = 1'b1;
              state_d = S_WB;
            end
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          pc_we     = 1'b1;
          wb_sel    = (cls_q == C_LOAD) ? 2'b01 : 2'b00;
          state_d   = S_FETCH;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cls_q     <= C_NONE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      illegal_q <= illegal_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;

`ifdef MC_CONTROL_INSTRET_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk) begin
    if (rst)        instret_q <= '0;
    else if (pc_we) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: a per-instruction cycle plan built from the ISA rules is
// compared against the DUT outputs on every falling edge, plus directed reset checks.
`timescale 1ns/1ps
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       br_taken = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we;
  logic [1:0] pc_src, alu_src, wb_sel;
  logic [3:0] alu_op;
  logic       reg_write, illegal;
  logic [2:0] state;
`ifdef MC_CONTROL_INSTRET_EN
  logic [31:0] instret;
`endif

  mc_control dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .br_taken     (br_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .mdr_we       (mdr_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .alu_src      (alu_src),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .state        (state),
    .illegal      (illegal)
`ifdef MC_CONTROL_INSTRET_EN
    ,
    .instret      (instret)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STOR = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  // One clock cycle of an instruction: inputs to drive and outputs the DUT must show.
  typedef struct {
    logic       rdy;
    logic       br;
    logic [2:0] st;
    logic       mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we;
    logic [1:0] pc_src, alu_src;
    logic [3:0] alu_op;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       illegal;
  } cyc_t;

  cyc_t exp_q[$];
  cyc_t plan[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cyc_t idle(input logic [2:0] st);
    cyc_t c;
    c = '{rdy: 1'b1, br: 1'b0, st: st, mem_req: 1'b0, mem_we: 1'b0, addr_sel: 1'b0,
          ir_we: 1'b0, mdr_we: 1'b0, pc_we: 1'b0, pc_src: 2'b00, alu_src: 2'b00,
          alu_op: 4'd0, reg_write: 1'b0, wb_sel: 2'b00, illegal: 1'b0};
    return c;
  endfunction

  // ALU encoding of the RV32I arithmetic functions.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? 4'd1 : 4'd0;
      3'b001:  return 4'd2;
      3'b010:  return 4'd3;
      3'b011:  return 4'd4;
      3'b100:  return 4'd5;
      3'b101:  return alt ? 4'd7 : 4'd6;
      3'b110:  return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    logic [6:0] ops [7] = '{OP_R, OP_I, OP_LOAD, OP_STOR, OP_BR, OP_JAL, OP_JALR};
    bit ok = 1'b0;
    foreach (ops[i]) if (ops[i] == op) ok = 1'b1;
    if (op == OP_R) begin
      if (f7 != 7'h00 && f7 != 7'h20) ok = 1'b0;
      if (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101) ok = 1'b0;
    end
    return ok;
  endfunction

  // Build the full cycle-by-cycle plan of one instruction.
  task automatic plan_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic br, input int fetch_w, input int mem_w, input int halt_n);
    cyc_t c, m, w;
    plan.delete();
    c = idle(3'd0); c.mem_req = 1'b1; c.rdy = 1'b0;
    repeat (fetch_w) plan.push_back(c);
    c.rdy = 1'b1; c.ir_we = 1'b1;
    plan.push_back(c);
    plan.push_back(idle(3'd1));
    if (!is_legal(op, f3, f7)) begin
      c = idle(3'd5); c.illegal = 1'b1;
      repeat (halt_n) plan.push_back(c);
      return;
    end
    c = idle(3'd2); c.br = br;
    w = idle(3'd4); w.reg_write = 1'b1; w.pc_we = 1'b1;
    case (op)
      OP_R: begin
        c.alu_op = arith_op(f3, f7[5]);
        plan.push_back(c); plan.push_back(w);
      end
      OP_I: begin
        c.alu_src = 2'b01; c.alu_op = arith_op(f3, (f3 == 3'b101) && f7[5]);
        plan.push_back(c); plan.push_back(w);
      end
      OP_LOAD, OP_STOR: begin
        c.alu_src = 2'b01;
        plan.push_back(c);
        m = idle(3'd3); m.mem_req = 1'b1; m.addr_sel = 1'b1; m.alu_src = 2'b01;
        m.mem_we = (op == OP_STOR); m.rdy = 1'b0;
        repeat (mem_w) plan.push_back(m);
        m.rdy = 1'b1;
        if (op == OP_STOR) m.pc_we = 1'b1; else m.mdr_we = 1'b1;
        plan.push_back(m);
        if (op == OP_LOAD) begin
          w.wb_sel = 2'b01; plan.push_back(w);
        end
      end
      OP_BR: begin
        c.alu_op = (f3[2:1] == 2'b10) ? 4'd3 : (f3[2:1] == 2'b11) ? 4'd4 : 4'd1;
        c.pc_we = 1'b1; c.pc_src = br ? 2'b01 : 2'b00;
        plan.push_back(c);
      end
      OP_JAL: begin
        c.pc_we = 1'b1; c.pc_src = 2'b01; c.reg_write = 1'b1; c.wb_sel = 2'b10;
        plan.push_back(c);
      end
      default: begin
        c.alu_src = 2'b01; c.pc_we = 1'b1; c.pc_src = 2'b10; c.reg_write = 1'b1; c.wb_sel = 2'b10;
        plan.push_back(c);
      end
    endcase
  endtask

  // Called just after a rising edge; leaves the bench just after the last cycle's rising edge.
  task automatic drive_plan();
    foreach (plan[i]) begin
      mem_ready = plan[i].rdy;
      br_taken  = plan[i].br;
      exp_q.push_back(plan[i]);
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic br, input int fetch_w, input int mem_w, input int halt_n);
    opcode = op; funct3 = f3; funct7 = f7;
    plan_instr(op, f3, f7, br, fetch_w, mem_w, halt_n);
    drive_plan();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; mem_ready = 1'b1;
    repeat (n) begin
      @(negedge clk);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_strobes", {ir_we, mdr_we, pc_we, reg_write}, 4'b0000);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    check("post_rst_state", state, 3'd0);
    check("post_rst_illegal", illegal, 1'b0);
  endtask

  // Compare process: every cycle with a planned expectation is checked on the falling edge.
  initial begin
    cyc_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state", state, e.st);
        check("mem_req", mem_req, e.mem_req);
        check("mem_we", mem_we, e.mem_we);
        check("mem_addr_sel", mem_addr_sel, e.addr_sel);
        check("ir_we", ir_we, e.ir_we);
        check("mdr_we", mdr_we, e.mdr_we);
        check("pc_we", pc_we, e.pc_we);
        check("pc_src", pc_src, e.pc_src);
        check("alu_src", alu_src, e.alu_src);
        check("alu_op", alu_op, e.alu_op);
        check("reg_write", reg_write, e.reg_write);
        check("wb_sel", wb_sel, e.wb_sel);
        check("illegal", illegal, e.illegal);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc_t c;
    do_reset(2);

    run(OP_R, 3'b000, 7'h00, 1'b0, 0, 0, 0);                  // ADD
    check("add_cycles", plan.size(), 4);
    check("add_exec_op", plan[2].alu_op, 4'b0000);
    run(OP_R, 3'b000, 7'h20, 1'b0, 0, 0, 0);                  // SUB
    check("sub_exec_op", plan[2].alu_op, 4'b0001);
    run(OP_I, 3'b101, 7'h20, 1'b0, 0, 0, 0);                  // SRAI
    check("srai_exec_op", plan[2].alu_op, 4'b0111);
    check("srai_alu_src", plan[2].alu_src, 2'b01);
    run(OP_I, 3'b000, 7'h20, 1'b0, 0, 0, 0);                  // ADDI, funct7 ignored
    check("addi_exec_op", plan[2].alu_op, 4'b0000);
    run(OP_R, 3'b100, 7'h00, 1'b0, 1, 0, 0);                  // XOR, fetch wait
    run(OP_R, 3'b011, 7'h00, 1'b0, 0, 0, 0);                  // SLTU
    run(OP_R, 3'b101, 7'h20, 1'b0, 0, 0, 0);                  // SRA
    run(OP_I, 3'b110, 7'h00, 1'b0, 0, 0, 0);                  // ORI
    run(OP_I, 3'b111, 7'h00, 1'b0, 0, 0, 0);                  // ANDI

    run(OP_LOAD, 3'b010, 7'h00, 1'b0, 0, 2, 0);               // LW, 2 MEM waits
    check("lw_cycles", plan.size(), 7);
    check("lw_wb_sel", plan[6].wb_sel, 2'b01);
    run(OP_STOR, 3'b010, 7'h00, 1'b0, 1, 1, 0);               // SW, waits in FETCH and MEM
    check("sw_cycles", plan.size(), 6);

    run(OP_BR, 3'b110, 7'h00, 1'b1, 0, 0, 0);                 // BLTU taken
    check("bltu_cycles", plan.size(), 3);
    check("bltu_op", plan[2].alu_op, 4'b0100);
    check("bltu_t_src", plan[2].pc_src, 2'b01);
    run(OP_BR, 3'b110, 7'h00, 1'b0, 0, 0, 0);                 // BLTU not taken
    check("bltu_nt_src", plan[2].pc_src, 2'b00);
    run(OP_BR, 3'b000, 7'h00, 1'b1, 0, 0, 0);                 // BEQ
    run(OP_BR, 3'b101, 7'h00, 1'b0, 0, 0, 0);                 // BGE
    run(OP_JAL, 3'b000, 7'h00, 1'b0, 0, 0, 0);
    run(OP_JALR, 3'b000, 7'h00, 1'b0, 0, 0, 0);

    run(7'h7f, 3'b000, 7'h00, 1'b0, 0, 0, 10);                // bad opcode
    check("halt_plan_state", plan[2].st, 3'd5);
    do_reset(1);
    run(OP_R, 3'b000, 7'h01, 1'b0, 0, 0, 3);                  // bad funct7
    do_reset(1);
    run(OP_R, 3'b001, 7'h20, 1'b0, 0, 0, 3);                  // alt funct7 on SLL
    do_reset(1);

    // Reset during a FETCH wait: the request is abandoned without any strobe.
    opcode = OP_R; funct3 = 3'b000; funct7 = 7'h00;
    plan.delete();
    c = idle(3'd0); c.mem_req = 1'b1; c.rdy = 1'b0;
    plan.push_back(c); plan.push_back(c);
    drive_plan();
    do_reset(1);
    run(OP_R, 3'b000, 7'h00, 1'b0, 0, 0, 0);

`ifdef MC_CONTROL_INSTRET_EN
    do_reset(1);
    check("instret_reset", instret, 32'd0);
    run(OP_R, 3'b000, 7'h00, 1'b0, 0, 0, 0);
    run(OP_JAL, 3'b000, 7'h00, 1'b0, 0, 0, 0);
    run(OP_STOR, 3'b010, 7'h00, 1'b0, 0, 0, 0);
    check("instret_count", instret, 32'd3);
`endif

    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
